// File: rtl/crcu_pkg.sv
// -----------------------------------------------------------------------------
// crcu_pkg
// Shared definitions for the CRCU reset-control APB register block:
//   - CTL word bit positions and the writable-bit mask
//   - register address offsets and the ID constant
//   - APB slave FSM state encoding
// Optional feature macro used by the importing RTL: CRCU_RST_LOCK_EN
// -----------------------------------------------------------------------------
package crcu_pkg;

   // CTL word fields
   localparam int          CTL_EN_BIT    = 0;
   localparam int          CTL_ASYNC_BIT = 1;   // 1 = async, 0 = sync
   localparam int          CTL_POL_BIT   = 2;   // 1 = posedge, 0 = negedge
   localparam logic [31:0] CTL_WMASK     = 32'h0000_0007;

   // Address map (byte offsets, word aligned)
   localparam logic [31:0] CTL_BASE   = 32'h0000_0000;
   localparam logic [31:0] STATUS_OFS = 32'h0000_0020;
   localparam logic [31:0] ID_OFS     = 32'h0000_0024;
   localparam logic [31:0] LOCK_OFS   = 32'h0000_003C;
   localparam logic [31:0] ID_VALUE   = 32'h4352_4355;
   localparam logic [7:0]  LOCK_KEY   = 8'hA5;

   // APB slave sequencing states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   // Keep only the implemented CTL bits; reserved bits always read 0.
   function automatic logic [31:0] ctl_mask(input logic [31:0] value);
      return value & CTL_WMASK;
   endfunction

endpackage

// File: rtl/crcu_apb_slave_fsm.sv
// -----------------------------------------------------------------------------
// crcu_apb_slave_fsm
// APB3 slave sequencing: tracks PSEL/PENABLE, inserts WAIT_STATES extra ACCESS
// cycles and produces a registered PREADY. The transfer address, direction and
// write data are latched when the setup phase is accepted, so the decode in the
// parent runs from registered values.
//
// Handshake: a transfer starts with PSEL=1,PENABLE=0 seen in IDLE; the master
// then holds PSEL=1,PENABLE=1 and all transfer fields stable until it samples
// PREADY=1. PREADY is high for exactly one cycle and commit_o is high in that
// same cycle; the clock edge closing that cycle is the commit edge. Dropping
// PSEL or PENABLE before PREADY aborts the transfer with no commit.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   psel, penable       APB control
//   pwrite, paddr,
//   pwdata              APB transfer fields (sampled at setup acceptance)
//   pready_o            registered PREADY
//   commit_o            single-cycle commit strobe (coincides with PREADY)
//   addr_o, write_o,
//   wdata_o             latched transfer fields
//   state_o             current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module crcu_apb_slave_fsm
   import crcu_pkg::*;
#(
   parameter int ADDR_W      = 6,
   parameter int WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [31:0]       pwdata,
   output logic              pready_o,
   output logic              commit_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic              write_o,
   output logic [31:0]       wdata_o,
   output apb_state_e        state_o
);

   localparam logic [2:0] WAIT_CNT = 3'(WAIT_STATES);

   apb_state_e        state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              pready_q, pready_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              write_q, write_d;
   logic [31:0]       wdata_q, wdata_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pready_d = 1'b0;
      addr_d   = addr_q;
      write_d  = write_q;
      wdata_d  = wdata_q;
      case (state_q)
         IDLE: begin
            // PSEL with PENABLE already high is not a valid setup phase.
            if (psel && !penable) begin
               state_d = SETUP;
               addr_d  = paddr;
               write_d = pwrite;
               wdata_d = pwdata;
            end
         end
         SETUP: begin
            state_d = ACCESS;
            cnt_d   = WAIT_CNT;
            // PREADY is registered, so it is raised one edge early: with no
            // wait states it appears in the first ACCESS cycle.
            if (psel && penable && (WAIT_CNT == 3'd0)) begin
               pready_d = 1'b1;
            end
         end
         ACCESS: begin
            if (pready_q) begin
               state_d = IDLE;
            end else if (!psel || !penable) begin
               state_d = IDLE;
               cnt_d   = 3'd0;
            end else if (cnt_q > 3'd1) begin
               cnt_d = cnt_q - 3'd1;
            end else begin
               // Last wait cycle (or none left): PREADY shows next cycle.
               cnt_d    = 3'd0;
               pready_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= 3'd0;
         pready_q <= 1'b0;
         addr_q   <= '0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pready_q <= pready_d;
         addr_q   <= addr_d;
         write_q  <= write_d;
         wdata_q  <= wdata_d;
      end
   end

   assign pready_o = pready_q;
   assign commit_o = pready_q;
   assign addr_o   = addr_q;
   assign write_o  = write_q;
   assign wdata_o  = wdata_q;
   assign state_o  = state_q;

endmodule

// File: rtl/crcu_rst_apb_regs.sv
// -----------------------------------------------------------------------------
// crcu_rst_apb_regs
// APB3 register file holding the per-domain reset control words (EN, ASYNC,
// POL) that feed the CRCU reset generators. Adds address/error decode, a
// STATUS view of all EN bits, a fixed ID word and a one-cycle change strobe
// per control register.
//
// Optional feature macro: CRCU_RST_LOCK_EN
//   defined     -> LOCK register at 0x3C; writing 8'hA5 sets a sticky lock
//                  that makes every CTL write fail with PSLVERR.
//   not defined -> 0x3C is unmapped; CTL registers are always writable.
//
// Ports:
//   CRCU_CLK, CRCU_RST    clock, asynchronous active-high reset
//   PSEL .. PWDATA        APB3 slave inputs
//   PREADY, PRDATA,
//   PSLVERR               APB3 slave outputs (PRDATA/PSLVERR zero unless PREADY)
//   rst_ctl_reg           CTL[i] on bits [32i+31:32i]
//   rst_ctl_upd           bit i pulses one cycle after CTL[i] changed value
// -----------------------------------------------------------------------------
module crcu_rst_apb_regs
   import crcu_pkg::*;
#(
   parameter int          NUM_RST_REGS = 4,
   parameter int          ADDR_W       = 6,
   parameter int          WAIT_STATES  = 1,
   parameter logic [31:0] RST_CTL_INIT = 32'h0000_0000
) (
   input  logic                      CRCU_CLK,
   input  logic                      CRCU_RST,
   input  logic                      PSEL,
   input  logic                      PENABLE,
   input  logic                      PWRITE,
   input  logic [ADDR_W-1:0]         PADDR,
   input  logic [31:0]               PWDATA,
   output logic                      PREADY,
   output logic [31:0]               PRDATA,
   output logic                      PSLVERR,
   output logic [32*NUM_RST_REGS-1:0] rst_ctl_reg,
   output logic [NUM_RST_REGS-1:0]   rst_ctl_upd
);

   localparam logic [31:0] CTL_SPAN = 32'(4 * NUM_RST_REGS);

   // Transfer interface from the sequencing FSM
   logic              fsm_pready;
   logic              fsm_commit;
   logic [ADDR_W-1:0] a_addr;
   logic              a_write;
   logic [31:0]       a_wdata;
   apb_state_e        fsm_state;

   crcu_apb_slave_fsm #(
      .ADDR_W      (ADDR_W),
      .WAIT_STATES (WAIT_STATES)
   ) u_fsm (
      .clk      (CRCU_CLK),
      .rst      (CRCU_RST),
      .psel     (PSEL),
      .penable  (PENABLE),
      .pwrite   (PWRITE),
      .paddr    (PADDR),
      .pwdata   (PWDATA),
      .pready_o (fsm_pready),
      .commit_o (fsm_commit),
      .addr_o   (a_addr),
      .write_o  (a_write),
      .wdata_o  (a_wdata),
      .state_o  (fsm_state)
   );

   // Register storage
   logic [31:0]             ctl_q [NUM_RST_REGS];
   logic [31:0]             ctl_d [NUM_RST_REGS];
   logic [NUM_RST_REGS-1:0] upd_q, upd_d;
   logic                    lock_q, lock_d;

   // Decode of the latched address
   logic [31:0]             addr32;
   logic [31:0]             ctl_ofs;
   logic                    misaligned;
   logic                    is_ctl;
   logic [NUM_RST_REGS-1:0] ctl_hit;
   logic                    is_status;
   logic                    is_id;
   logic                    is_lock;
   logic                    dec_err;
   logic [31:0]             status_word;
   logic [31:0]             rd_data;
   logic                    commit_ok;
   logic                    wr_ok;

   always_comb begin
      addr32             = '0;
      addr32[ADDR_W-1:0] = a_addr;
      ctl_ofs            = addr32 - CTL_BASE;
      misaligned         = |addr32[1:0];
      is_ctl             = !misaligned && (ctl_ofs < CTL_SPAN);
      ctl_hit            = '0;
      for (int i = 0; i < NUM_RST_REGS; i++) begin
         if (is_ctl && (ctl_ofs[31:2] == 30'(i))) begin
            ctl_hit[i] = 1'b1;
         end
      end
      is_status = (addr32 == STATUS_OFS);
      is_id     = (addr32 == ID_OFS);
`ifdef CRCU_RST_LOCK_EN
      is_lock   = (addr32 == LOCK_OFS);
`else
      is_lock   = 1'b0;
`endif

      // Unmapped, misaligned, read-only written, or CTL written while locked.
      dec_err = misaligned
              || !(is_ctl || is_status || is_id || is_lock)
              || (a_write && (is_status || is_id))
              || (a_write && is_ctl && lock_q);

      status_word = '0;
      for (int i = 0; i < NUM_RST_REGS; i++) begin
         status_word[i] = ctl_q[i][CTL_EN_BIT];
      end

      rd_data = '0;
      for (int i = 0; i < NUM_RST_REGS; i++) begin
         if (ctl_hit[i]) begin
            rd_data = ctl_q[i];
         end
      end
      if (is_status) begin
         rd_data = status_word;
      end
      if (is_id) begin
         rd_data = ID_VALUE;
      end
      if (is_lock) begin
         rd_data = {31'b0, lock_q};
      end
   end

   // The commit strobe is only meaningful while the FSM sits in ACCESS.
   assign commit_ok = fsm_commit && (fsm_state == ACCESS);
   assign wr_ok     = commit_ok && a_write && !dec_err;

   always_comb begin
      ctl_d  = ctl_q;
      upd_d  = '0;
      lock_d = lock_q;
      for (int i = 0; i < NUM_RST_REGS; i++) begin
         if (wr_ok && ctl_hit[i]) begin
            ctl_d[i] = ctl_mask(a_wdata);
            upd_d[i] = (ctl_d[i] != ctl_q[i]);
         end
      end
`ifdef CRCU_RST_LOCK_EN
      // Only the key value arms the lock; any other write is silently dropped.
      if (wr_ok && is_lock && (a_wdata[7:0] == LOCK_KEY)) begin
         lock_d = 1'b1;
      end
`endif
   end

   always_ff @(posedge CRCU_CLK or posedge CRCU_RST) begin
      if (CRCU_RST) begin
         for (int i = 0; i < NUM_RST_REGS; i++) begin
            ctl_q[i] <= ctl_mask(RST_CTL_INIT);
         end
         upd_q  <= '0;
         lock_q <= 1'b0;
      end else begin
         ctl_q  <= ctl_d;
         upd_q  <= upd_d;
         lock_q <= lock_d;
      end
   end

   // APB outputs: data and error only qualified by PREADY; writes return 0.
   assign PREADY  = fsm_pready;
   assign PRDATA  = (fsm_pready && !a_write && !dec_err) ? rd_data : 32'h0;
   assign PSLVERR = fsm_pready && dec_err;

   for (genvar g = 0; g < NUM_RST_REGS; g++) begin : g_ctl_out
      assign rst_ctl_reg[32*g +: 32] = ctl_q[g];
   end

   assign rst_ctl_upd = upd_q;

endmodule

// File: doc/crcu_rst_apb_regs.md
Name: crcu_rst_apb_regs

Overview:
APB3 slave register file holding the per-domain reset control words (EN, ASYNC, POL) for the CRCU.
- Sits directly upstream of the per-domain reset generators, e.g. the load-domain reset control stage.
- Each rst_ctl_reg word drives one generator.
- Adds programmable wait states, address/error decode, a status/ID view and a one-cycle update strobe per register.

Parameters:
NUM_RST_REGS, 4, number of reset control registers (1..8)
ADDR_W, 6, PADDR width in bits
WAIT_STATES, 1, extra ACCESS cycles before PREADY (0..7)
RST_CTL_INIT, 32'h0000_0000, reset value of every control register

Ports:
CRCU_CLK  in  1  block clock; all logic on rising edge
CRCU_RST  in  1  asynchronous, active-high reset
PSEL  in  1  APB select
PENABLE  in  1  APB enable
PWRITE  in  1  1 = write, 0 = read
PADDR  in  ADDR_W  byte address
PWDATA  in  32  write data
PREADY  out  1  transfer complete
PRDATA  out  32  read data, valid only while PREADY=1
PSLVERR  out  1  error, valid only while PREADY=1
rst_ctl_reg  out  32*NUM_RST_REGS  control words; register i occupies bits [32i+31:32i]
rst_ctl_upd  out  NUM_RST_REGS  one-cycle strobe, register i changed value

Behaviour:
- Reset (CRCU_RST=1, asynchronous):
  - FSM enters IDLE; wait counter cleared.
  - PREADY, PSLVERR, rst_ctl_upd = 0; PRDATA = 0.
  - Every control register = RST_CTL_INIT & 32'h7.
- Register fields:
  - bit0 EN, bit1 ASYNC (1 = async, 0 = sync), bit2 POL (1 = posedge, 0 = negedge).
  - Bits [31:3] are reserved: write-ignored, read 0.
- Address map (word-aligned):
  - 0x00 + 4i: CTL[i], read/write, for i < NUM_RST_REGS.
  - 0x20: STATUS, read-only; bit i = CTL[i].EN, upper bits 0.
  - 0x24: ID, read-only, 32'h4352_4355.
  - 0x3C: LOCK, only when CRCU_RST_LOCK_EN is defined.
- FSM states:
  - IDLE: PSEL=1 and PENABLE=0 -> SETUP. PSEL=1 and PENABLE=1 (protocol violation) -> stays IDLE, transfer ignored, PREADY stays 0.
  - SETUP: always -> ACCESS; wait counter loads WAIT_STATES.
  - ACCESS:
    - PSEL=0 or PENABLE=0 -> IDLE: transfer aborted, no register update.
    - Counter > 0 -> decrement.
    - Counter == 0 -> PREADY=1 for exactly one cycle, then -> IDLE.
    - Back-to-back: a new SETUP is accepted in the cycle after PREADY.
- Latency: PREADY rises WAIT_STATES+1 cycles after the first PENABLE cycle. With WAIT_STATES=0, PREADY rises in the first PENABLE cycle after the registered decode.
- Write commit:
  - Target register updates on the clock edge where PREADY=1 and PWRITE=1 and no error.
  - rst_ctl_upd[i] pulses in the following cycle, only if the new masked value differs from the old.
- Errors, all with PSLVERR=1 alongside PREADY=1:
  - PADDR[1:0] != 0.
  - Unmapped address.
  - Write to STATUS or ID.
  - Errored write: no register changes. Errored read: PRDATA = 0.
- PRDATA and PSLVERR are forced to 0 whenever PREADY=0.
- Reset asserted mid-transfer: transfer lost, outputs return to reset values immediately.

Optional Feature:
CRCU_RST_LOCK_EN
- Defined:
  - LOCK register at 0x3C. Writing PWDATA[7:0] = 8'hA5 sets the sticky lock bit; other values are ignored, no error.
  - Reading 0x3C returns {31'b0, lock}.
  - Lock clears only on CRCU_RST.
  - While locked, any CTL write completes with PSLVERR=1, no update and no upd strobe.
- Not defined: 0x3C is unmapped (PSLVERR on access); CTL registers are always writable.

Decomposition:
- Shared package crcu_pkg:
  - CTL bit-position constants (EN=0, ASYNC=1, POL=2) and CTL_WMASK = 32'h7.
  - Address offsets (CTL_BASE, STATUS_OFS, ID_OFS, LOCK_OFS) and ID_VALUE.
  - APB FSM state enum {IDLE, SETUP, ACCESS}.
- One natural sub-module: crcu_apb_slave_fsm.
  - Owns PSEL/PENABLE sequencing, wait counter and PREADY generation.
  - Outputs a single-cycle commit strobe plus latched address, write flag and data.
- Decode and register storage stay in the top module.

Test Plan:
- Reset with RST_CTL_INIT = 32'hFFFF_FFFF -> every rst_ctl_reg word = 32'h7; PREADY=0, PRDATA=0.
- WAIT_STATES=1: write 0x04 <- 32'hFFFF_FFF5, then read 0x04 -> PREADY after 2 ENABLE cycles; read returns 32'h5; rst_ctl_upd = 4'b0010 for one cycle; STATUS reads 32'h2.
- Rewrite 0x04 with same value 32'h5 -> no rst_ctl_upd pulse.
- Accesses to 0x06, 0x30, and a write to 0x24 -> PSLVERR=1, PRDATA=0, registers unchanged.
- PSEL dropped mid-ACCESS during a write to 0x00 <- 32'h7 -> PREADY never asserts; CTL[0] unchanged.
- CRCU_RST_LOCK_EN defined: write 0x3C <- 32'hA5, then write 0x00 <- 32'h1 -> PSLVERR=1, CTL[0] unchanged; after CRCU_RST pulse, the same write succeeds.
